// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling FSM and a
// single-entry holding register with a sticky overrun flag.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s to fall
// START | timing half a bit, then confirming the start bit
// DATA  | sampling the 8 data bits, LSB first
// STOP  | sampling the stop bit
// BREAK | stop bit was low; waiting for the line to return high
module uart_receiver #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF_LAST = 8'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t     state, state_nxt;
  logic       sync_1, rx_s;
  logic [7:0] tick, tick_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic       sample;
  logic       byte_done;
  logic       stop_bad;
  logic       pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= ser_in;
      rx_s   <= sync_1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tick    <= 8'd0;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
    end else begin
      state   <= state_nxt;
      tick    <= tick_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
    end
  end

  // The tick counter is loaded one short so the sample lands on the cycle it
  // reaches zero; it never decrements below zero.
  always_comb begin
    state_nxt   = state;
    tick_nxt    = tick;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    byte_done   = 1'b0;
    stop_bad    = 1'b0;
    sample      = (tick == 8'd0);
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt   = START;
          tick_nxt    = HALF_LAST;
          bit_cnt_nxt = 3'd0;
        end
      end
      START: begin
        if (sample) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            tick_nxt  = BIT_LAST;
          end
        end else begin
          tick_nxt = tick - 8'd1;
        end
      end
      DATA: begin
        if (sample) begin
          shift_nxt   = {rx_s, shift[7:1]};
          tick_nxt    = BIT_LAST;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          tick_nxt = tick - 8'd1;
        end
      end
      STOP: begin
        if (sample) begin
          if (rx_s) begin
            byte_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          tick_nxt = tick - 8'd1;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign pop  = valid && rd;
  assign busy = (state != IDLE);

  // A completing byte may replace the held one only when the slot is empty
  // or being read in the same cycle; otherwise it is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (byte_done && (!valid || pop)) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
      if (pop) begin
        overrun <= 1'b0;
      end else if (byte_done && valid) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a fast (2 clk/bit) and a slow (16 clk/bit) instance,
// each compared every cycle against a frame-timing model driven by the same line.
module tb_uart_receiver;

  localparam int NU = 2;
  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_BREAK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser     [NU];
  logic       rd      [NU];
  logic [7:0] data_o  [NU];
  logic       valid_o [NU];
  logic       ferr_o  [NU];
  logic       ovr_o   [NU];
  logic       busy_o  [NU];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(2)) dut_fast (
    .clk(clk), .rst(rst), .ser_in(ser[0]), .rd(rd[0]),
    .data(data_o[0]), .valid(valid_o[0]), .frame_err(ferr_o[0]),
    .overrun(ovr_o[0]), .busy(busy_o[0])
  );

  uart_receiver #(.CLKS_PER_BIT(16)) dut_slow (
    .clk(clk), .rst(rst), .ser_in(ser[1]), .rd(rd[1]),
    .data(data_o[1]), .valid(valid_o[1]), .frame_err(ferr_o[1]),
    .overrun(ovr_o[1]), .busy(busy_o[1])
  );

  function automatic int cpb(int u);
    return (u == 0) ? 2 : 16;
  endfunction

  // model state: line delayed by two clocks, frame start time, holding register
  int         m_mode  [NU];
  int         m_cyc   [NU];
  int         m_t0    [NU];
  logic       m_s1    [NU];
  logic       m_rx    [NU];
  logic [7:0] m_shift [NU];
  logic [7:0] m_data  [NU];
  logic       m_valid [NU];
  logic       m_ovr   [NU];
  logic       m_ferr  [NU];
  int         m_same  [NU];
  int         ferr_cnt[NU];
  bit         traffic_done[NU];

  task automatic model_step(int u);
    int   p, h, k, idx;
    logic rx, done, ferr;
    p = cpb(u);
    h = p / 2;
    rx = m_rx[u];
    done = 1'b0;
    ferr = 1'b0;
    if (m_mode[u] == M_IDLE) begin
      if (!rx) begin
        m_mode[u] = M_FRAME;
        m_t0[u]   = m_cyc[u];
      end
    end else if (m_mode[u] == M_FRAME) begin
      k = m_cyc[u] - m_t0[u] - h;
      if (k >= 0 && (k % p) == 0) begin
        idx = k / p;
        if (idx == 0) begin
          if (rx) m_mode[u] = M_IDLE;
        end else if (idx <= 8) begin
          m_shift[u][idx-1] = rx;
        end else if (rx) begin
          done = 1'b1;
          m_mode[u] = M_IDLE;
        end else begin
          ferr = 1'b1;
          m_mode[u] = M_BREAK;
        end
      end
    end else begin
      if (rx) m_mode[u] = M_IDLE;
    end
    if (done && m_valid[u] && rd[u]) m_same[u]++;
    if (done) begin
      if (!m_valid[u] || rd[u]) begin
        m_data[u] = m_shift[u];
        m_valid[u] = 1'b1;
        m_ovr[u] = 1'b0;
      end else begin
        m_ovr[u] = 1'b1;
      end
    end else if (m_valid[u] && rd[u]) begin
      m_valid[u] = 1'b0;
      m_ovr[u] = 1'b0;
    end
    m_ferr[u] = ferr;
    m_rx[u] = m_s1[u];
    m_s1[u] = ser[u];
    m_cyc[u]++;
  endtask

  always @(posedge clk or posedge rst) begin
    for (int u = 0; u < NU; u++) begin
      if (rst) begin
        m_mode[u]  = M_IDLE;
        m_cyc[u]   = 0;
        m_t0[u]    = 0;
        m_s1[u]    = 1'b1;
        m_rx[u]    = 1'b1;
        m_shift[u] = 8'h00;
        m_data[u]  = 8'h00;
        m_valid[u] = 1'b0;
        m_ovr[u]   = 1'b0;
        m_ferr[u]  = 1'b0;
      end else begin
        model_step(u);
      end
    end
  end

  task automatic chk(string name, int u, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s unit%0d t=%0t got=%h expected=%h", name, u, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      chk("data", u, data_o[u], m_data[u]);
      chk("valid", u, {7'd0, valid_o[u]}, {7'd0, m_valid[u]});
      chk("frame_err", u, {7'd0, ferr_o[u]}, {7'd0, m_ferr[u]});
      chk("overrun", u, {7'd0, ovr_o[u]}, {7'd0, m_ovr[u]});
      chk("busy", u, {7'd0, busy_o[u]}, {7'd0, (m_mode[u] != M_IDLE)});
      if (ferr_o[u] === 1'b1) ferr_cnt[u]++;
    end
  end

  task automatic idle_cycles(int u, int n);
    ser[u] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(int u, logic [7:0] b, logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser[u] = f[i];
      repeat (cpb(u)) @(negedge clk);
    end
  endtask

  task automatic pop(int u);
    rd[u] = 1'b1;
    @(negedge clk);
    rd[u] = 1'b0;
  endtask

  task automatic wait_not_busy(int u, int budget, string name);
    int n;
    n = 0;
    while (busy_o[u] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_o[u] !== 1'b0) begin
      failures++;
      $display("FAIL %s unit%0d busy=%b after %0d cycles, required 0", name, u, busy_o[u], budget);
    end
  endtask

  task automatic rand_traffic(int u, int n);
    traffic_done[u] = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int r;
          r = $urandom_range(0, 9);
          if (r == 0) begin
            ser[u] = 1'b0;
            repeat ($urandom_range(1, cpb(u) / 2 + 1)) @(negedge clk);
            idle_cycles(u, 10 * cpb(u));
          end else if (r == 1) begin
            send(u, 8'($urandom), 1'b0);
            ser[u] = 1'b0;
            repeat ($urandom_range(0, 30)) @(negedge clk);
            idle_cycles(u, $urandom_range(1, 5));
          end else begin
            send(u, 8'($urandom), 1'b1);
            idle_cycles(u, $urandom_range(0, 3));
          end
        end
        traffic_done[u] = 1'b1;
      end
      begin
        while (!traffic_done[u]) begin
          rd[u] = ($urandom_range(0, 3) == 0);
          @(negedge clk);
        end
        rd[u] = 1'b0;
      end
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc, sc;
    rst = 1'b1;
    for (int u = 0; u < NU; u++) begin
      ser[u] = 1'b1;
      rd[u]  = 1'b0;
      ferr_cnt[u] = 0;
      m_same[u] = 0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      chk("reset_data", u, data_o[u], 8'h00);
      chk("reset_valid", u, {7'd0, valid_o[u]}, 8'd0);
      chk("reset_busy", u, {7'd0, busy_o[u]}, 8'd0);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    idle_cycles(0, 5);

    // single frame, nothing read
    send(0, 8'hA5, 1'b1);
    idle_cycles(0, 4);
    chk("model_a5", 0, m_data[0], 8'hA5);
    chk("a5_data", 0, data_o[0], 8'hA5);
    chk("a5_valid", 0, {7'd0, valid_o[0]}, 8'd1);
    chk("a5_overrun", 0, {7'd0, ovr_o[0]}, 8'd0);
    pop(0);
    idle_cycles(0, 2);

    // back-to-back frames, first one read during the second
    fork
      begin send(0, 8'h3C, 1'b1); send(0, 8'hC3, 1'b1); end
      begin repeat (25) @(negedge clk); pop(0); end
    join
    idle_cycles(0, 4);
    chk("b2b_rd_data", 0, data_o[0], 8'hC3);
    chk("b2b_rd_valid", 0, {7'd0, valid_o[0]}, 8'd1);
    chk("b2b_rd_overrun", 0, {7'd0, ovr_o[0]}, 8'd0);
    pop(0);
    idle_cycles(0, 2);
    send(0, 8'h3C, 1'b1);
    send(0, 8'hC3, 1'b1);
    idle_cycles(0, 4);
    chk("model_ovr_data", 0, m_data[0], 8'h3C);
    chk("b2b_nord_data", 0, data_o[0], 8'h3C);
    chk("b2b_nord_overrun", 0, {7'd0, ovr_o[0]}, 8'd1);
    pop(0);
    idle_cycles(0, 2);
    chk("pop_clears_ovr", 0, {7'd0, ovr_o[0]}, 8'd0);
    chk("pop_clears_valid", 0, {7'd0, valid_o[0]}, 8'd0);
    pop(0);
    idle_cycles(0, 2);

    // bad stop bit, long break, then a good frame
    fc = ferr_cnt[0];
    send(0, 8'h55, 1'b0);
    ser[0] = 1'b0;
    repeat (40) @(negedge clk);
    chk("break_busy", 0, {7'd0, busy_o[0]}, 8'd1);
    chk("break_valid", 0, {7'd0, valid_o[0]}, 8'd0);
    chk("break_ferr_pulses", 0, 8'(ferr_cnt[0] - fc), 8'd1);
    ser[0] = 1'b1;
    wait_not_busy(0, 6, "break_release");
    idle_cycles(0, 3);
    send(0, 8'h01, 1'b1);
    idle_cycles(0, 4);
    chk("after_break_data", 0, data_o[0], 8'h01);
    chk("after_break_valid", 0, {7'd0, valid_o[0]}, 8'd1);
    pop(0);
    idle_cycles(0, 2);

    // second byte completes in the same cycle as rd
    sc = m_same[0];
    fork
      begin send(0, 8'h0F, 1'b1); send(0, 8'hF0, 1'b1); end
      begin repeat (41) @(negedge clk); rd[0] = 1'b1; @(negedge clk); rd[0] = 1'b0; end
    join
    idle_cycles(0, 4);
    chk("same_cycle_seen", 0, 8'(m_same[0] - sc), 8'd1);
    chk("same_cycle_data", 0, data_o[0], 8'hF0);
    chk("same_cycle_valid", 0, {7'd0, valid_o[0]}, 8'd1);
    chk("same_cycle_overrun", 0, {7'd0, ovr_o[0]}, 8'd0);
    pop(0);
    idle_cycles(0, 2);

    // reset during data bit 4 of 0xFF, then a clean 0x12
    fc = ferr_cnt[0];
    ser[0] = 1'b0;
    repeat (2) @(negedge clk);
    ser[0] = 1'b1;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_data", 0, data_o[0], 8'h00);
    chk("midreset_valid", 0, {7'd0, valid_o[0]}, 8'd0);
    chk("midreset_busy", 0, {7'd0, busy_o[0]}, 8'd0);
    chk("midreset_ferr", 0, {7'd0, ferr_o[0]}, 8'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    idle_cycles(0, 20);
    chk("post_reset_valid", 0, {7'd0, valid_o[0]}, 8'd0);
    send(0, 8'h12, 1'b1);
    idle_cycles(0, 4);
    chk("post_reset_data", 0, data_o[0], 8'h12);
    chk("post_reset_valid2", 0, {7'd0, valid_o[0]}, 8'd1);
    chk("post_reset_noferr", 0, 8'(ferr_cnt[0] - fc), 8'd0);
    pop(0);

    // slow instance: short glitch rejected, then a real frame
    idle_cycles(1, 5);
    ser[1] = 1'b0;
    repeat (4) @(negedge clk);
    ser[1] = 1'b1;
    chk("glitch_busy_high", 1, {7'd0, busy_o[1]}, 8'd1);
    wait_not_busy(1, 9, "glitch_release");
    chk("glitch_valid", 1, {7'd0, valid_o[1]}, 8'd0);
    chk("glitch_data", 1, data_o[1], 8'h00);
    idle_cycles(1, 20);
    send(1, 8'h96, 1'b1);
    idle_cycles(1, 12);
    chk("slow_data", 1, data_o[1], 8'h96);
    chk("slow_valid", 1, {7'd0, valid_o[1]}, 8'd1);
    pop(1);
    idle_cycles(1, 2);

    fork
      rand_traffic(0, 60);
      rand_traffic(1, 12);
    join
    idle_cycles(0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
